bcd2bin: RTL and testbench

- Iterative packed-BCD to unsigned-binary converter. It is the inverse of the team's bin-to-BCD block and feeds decimal operands (keypad/display path) back into binary datapaths.
- Processes one decimal digit per clock, most significant digit first, using acc = acc*10 + digit.
- Valid/ready handshake on both input and output; the output is held until it is accepted.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd2bin_mac.sv | 35 +++
 rtl/bcd2bin.sv | 140 ++++++++++++++
 tb/tb_bcd2bin.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the packed-BCD to binary converter.
//   state_t       : converter FSM states (IDLE, CONV, DONE)
//   DIGIT_W       : width of one BCD digit
//   BCD_MAX_DIGIT : largest legal decimal digit value
//   min_bin_w()   : smallest BIN_W that holds 10^digits - 1 without wrapping
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W       = 4;
  localparam int BCD_MAX_DIGIT = 9;

  // 10^digits is never a power of two, so ceil(log2(10^digits)) is exactly
  // the number of bits needed for the largest value 10^digits - 1.
  function automatic int min_bin_w(input int digits);
    longint unsigned pow10;
    pow10 = 1;
    for (int i = 0; i < digits; i++) begin
      pow10 = pow10 * 10;
    end
    return $clog2(pow10);
  endfunction

endpackage

// File: rtl/bcd2bin_mac.sv
// -----------------------------------------------------------------------------
// bcd2bin_mac
// Combinational multiply-accumulate step: o_acc = (i_acc * 10 + i_digit)
// truncated to BIN_W bits, plus an invalid-digit flag when BCD2BIN_ERR_EN
// is defined.
//   i_acc       : running accumulator
//   i_digit     : next BCD digit, used at face value (0..15)
//   o_acc       : updated accumulator
//   o_digit_bad : digit > 9 (present only with BCD2BIN_ERR_EN)
// -----------------------------------------------------------------------------
module bcd2bin_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 10
) (
  input  logic [BIN_W-1:0]   i_acc,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [BIN_W-1:0]   o_acc
`ifdef BCD2BIN_ERR_EN
  ,
  output logic               o_digit_bad
`endif
);

  // acc*10 = acc*8 + acc*2. Addition and shifts only propagate carries
  // upward, so the low BIN_W bits of the full BIN_W+4 bit result equal the
  // same expression evaluated modulo 2^BIN_W; bits above BIN_W would only be
  // discarded by the truncation.
  assign o_acc = (i_acc << 3) + (i_acc << 1) + BIN_W'(i_digit);

`ifdef BCD2BIN_ERR_EN
  assign o_digit_bad = (i_digit > DIGIT_W'(BCD_MAX_DIGIT));
`endif

endmodule

// File: rtl/bcd2bin.sv
// -----------------------------------------------------------------------------
// bcd2bin
// Iterative packed-BCD to unsigned-binary converter. One digit per clock,
// most significant digit first (acc = acc*10 + digit). Valid/ready on both
// sides; the result is held until accepted.
// Optional feature: define BCD2BIN_ERR_EN to flag digits > 9 on err_out.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bcd_in    : packed BCD, digit DIGITS-1 in the MSBs
//   in_valid  : bcd_in valid
//   in_ready  : converter idle and accepting input
//   bin_out   : converted value, stable while out_valid
//   out_valid : bin_out/err_out valid
//   out_ready : consumer accepts the result
//   err_out   : invalid digit seen (0 unless BCD2BIN_ERR_EN)
// -----------------------------------------------------------------------------
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [BIN_W-1:0]          bin_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err_out
);

  localparam int                SH_W     = DIGIT_W * DIGITS;
  localparam int                CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIGITS - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [SH_W-1:0]   r_shreg;
  logic [BIN_W-1:0]  r_acc;
  logic [BIN_W-1:0]  r_bin;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIN_W-1:0]  w_acc_next;
  logic              w_accept;
  logic              w_last;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == CONV) && (r_cnt == CNT_LAST);

`ifdef BCD2BIN_ERR_EN
  logic w_digit_bad;
  logic r_err;
`endif

  bcd2bin_mac #(
    .BIN_W (BIN_W)
  ) u_mac (
    .i_acc       (r_acc),
    .i_digit     (r_shreg[SH_W-1 -: DIGIT_W]),
    .o_acc       (w_acc_next)
`ifdef BCD2BIN_ERR_EN
    ,
    .o_digit_bad (w_digit_bad)
`endif
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first guarantees every path drives
  // w_next_state, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next_state = CONV;
      CONV:    if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  // Accumulator, digit counter and held result. bin_out has its own register
  // so it only moves on the final CONV edge, not while acc is building up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_bin <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == CONV) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_bin <= w_acc_next;
      end
    end
  end

  // NOTE: the digit shift register carries no reset; it is always loaded on
  // acceptance before any digit is consumed, so its reset value is never seen.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shreg <= bcd_in;
    end else if (r_state == CONV) begin
      r_shreg <= r_shreg << DIGIT_W;
    end
  end

`ifdef BCD2BIN_ERR_EN
  // Sticky for one conversion, cleared when the next operand is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if ((r_state == CONV) && w_digit_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err_out = r_err && (r_state == DONE);
`else
  assign err_out = 1'b0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign bin_out   = r_bin;

endmodule

// File: tb/tb_bcd2bin.sv
// -----------------------------------------------------------------------------
// tb_bcd2bin
// Self-checking bench for bcd2bin. The main instance (3 digits, 10 bits) is
// driven through a scoreboard: expected results are queued at the input
// handshake and compared at the output handshake. Two extra instances cover
// DIGITS = 1 and DIGITS = 4. Honours BCD2BIN_ERR_EN for the error flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd2bin;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  typedef struct packed {
    logic             err;
    logic [BIN_W-1:0] bin;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [11:0]      bcd_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BIN_W-1:0] bin_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             err_out;

  logic        d1_in_valid = 1'b0, d1_in_ready, d1_out_valid, d1_err;
  logic [3:0]  d1_bcd = '0, d1_bin;
  logic        d4_in_valid = 1'b0, d4_in_ready, d4_out_valid, d4_err;
  logic [15:0] d4_bcd = '0;
  logic [13:0] d4_bin;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .in_valid(in_valid),
    .in_ready(in_ready), .bin_out(bin_out), .out_valid(out_valid),
    .out_ready(out_ready), .err_out(err_out)
  );

  bcd2bin #(.DIGITS(1), .BIN_W(4)) u_d1 (
    .clk(clk), .rst(rst), .bcd_in(d1_bcd), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .bin_out(d1_bin), .out_valid(d1_out_valid),
    .out_ready(1'b1), .err_out(d1_err)
  );

  bcd2bin #(.DIGITS(4), .BIN_W(14)) u_d4 (
    .clk(clk), .rst(rst), .bcd_in(d4_bcd), .in_valid(d4_in_valid),
    .in_ready(d4_in_ready), .bin_out(d4_bin), .out_valid(d4_out_valid),
    .out_ready(1'b1), .err_out(d4_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: decimal weighting of each nibble at face value.
  function automatic exp_t model(input logic [11:0] v);
    exp_t        e;
    int unsigned acc;
    logic [3:0]  d;
    acc   = 0;
    e.err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d   = v[i*4 +: 4];
      acc = acc * 10 + d;
`ifdef BCD2BIN_ERR_EN
      if (d > 4'd9) e.err = 1'b1;
`endif
    end
    e.bin = acc[BIN_W-1:0];
    return e;
  endfunction

  // Scoreboard: push at input handshake, compare at output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) sb_q.push_back(model(bcd_in));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", sb_q.size(), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_bin", bin_out, e.bin);
          check("sb_err", err_out, e.err);
        end
      end
    end
  end

  // Drive one operand and hold it until accepted. hs is the cycle count seen
  // just before the accepting edge.
  task automatic send(input logic [11:0] v, output int hs);
    bit ok;
    ok       = 1'b0;
    hs       = 0;
    bcd_in   = v;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        hs = cyc;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int seen);
    bit ok;
    ok   = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok   = 1'b1;
        seen = cyc;
        break;
      end
    end
    if (!ok) check("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, hs2, seen, ov_cnt;
    bit ok;

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bin_out", bin_out, 0);
    check("rst_err_out", err_out, 0);

    // ---- 000: latency and return to IDLE ----
    out_ready = 1'b1;
    send(12'h000, hs);
    wait_out(seen);
    check("latency_000", seen - (hs + 1), DIGITS);
    @(negedge clk);
    check("accept_out_valid_low", out_valid, 0);
    check("accept_in_ready_high", in_ready, 1);
    drain();

    // ---- 255 then 999 back-to-back with in_valid held ----
    bcd_in   = 12'h255;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; hs = cyc; break; end
    end
    @(posedge clk);
    #1 bcd_in = 12'h999;
    hs2 = hs;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin hs2 = cyc; break; end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("issue_interval_ok", (ok && (hs2 - hs >= DIGITS + 2)), 1);
    drain();

    // ---- 407 with a 6-cycle output stall and ignored input pulses ----
    out_ready = 1'b0;
    send(12'h407, hs);
    wait_out(seen);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 begin
        in_valid = k[0];
        bcd_in   = 12'h111;
      end
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_bin_out", bin_out, 407);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    drain();
    repeat (6) @(negedge clk);
    check("stall_no_extra_output", sb_q.size() + (out_valid ? 1 : 0), 0);

    // ---- invalid digit, then sticky-flag clear ----
    send(12'h1A3, hs);
    drain();
    send(12'h123, hs);
    drain();

    // ---- reset mid-conversion ----
    send(12'h888, hs);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    ov_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) ov_cnt++;
      @(negedge clk);
    end
    check("midrst_no_out_valid", ov_cnt, 0);
    send(12'h042, hs);
    wait_out(seen);
    check("post_rst_bin", bin_out, 42);
    drain();

    // ---- random operands with random output stalls ----
    for (int n = 0; n < 8; n++) begin
      out_ready = 1'b0;
      send(12'($urandom_range(0, 4095)), hs);
      wait_out(seen);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      drain();
    end

    // ---- DIGITS = 1 ----
    d1_bcd      = 4'h7;
    d1_in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d1_in_ready) begin ok = 1'b1; break; end
    end
    check("d1_handshake", ok, 1);
    @(posedge clk);
    #1 d1_in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check("d1_out_valid", d1_out_valid, (k == 2));
    end
    check("d1_bin", d1_bin, 7);
    check("d1_err", d1_err, 0);

    // ---- DIGITS = 4 ----
    d4_bcd      = 16'h9999;
    d4_in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d4_in_ready) begin ok = 1'b1; break; end
    end
    check("d4_handshake", ok, 1);
    @(posedge clk);
    #1 d4_in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("d4_out_valid", d4_out_valid, (k == 5));
    end
    check("d4_bin", d4_bin, 9999);
    check("d4_err", d4_err, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
